// File: rtl/paquete_multiplicacion.sv
// Shared types for the Booth multiplication subsystem: the datapath
// strobe bundle and the controller state encoding.
package paquete_multiplicacion;

  // Controller states; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CARGA    = 3'd1,
    EVALUA   = 3'd2,
    SUMA     = 3'd3,
    DESPLAZA = 3'd4,
    LISTO    = 3'd5
  } estado_t;

  // Datapath strobes. add_sub=1 selects add, add_sub=0 selects subtract.
  typedef struct packed {
    logic load_A;
    logic load_B;
    logic load_add;
    logic shift_HQ_LQ_Q_1;
    logic add_sub;
  } mult_control_t;

endpackage

// File: rtl/control_multiplicacion.sv
// Booth multiplier sequencer. One operation is CARGA, then N_BITS rounds
// of EVALUA -> (SUMA) -> DESPLAZA, then a single-cycle LISTO pulse.
//
// Handshake: banderaValida is a request that is only looked at while the
// block is in IDLE (ocupado=0); a request seen in any other state is
// dropped, not queued. banderaLista is a one-cycle completion pulse and
// needs no acknowledge.
module control_multiplicacion
  import paquete_multiplicacion::*;
#(
  parameter int N_BITS = 4
) (
  input  logic          reloj,
  input  logic          reinicio,
  input  logic          banderaValida,
  input  logic [1:0]    qlsb,
  output mult_control_t controladorMult,
  output logic          banderaLista,
  output logic          ocupado,
  output estado_t       estado
);

  localparam int CW = $clog2(N_BITS + 1);

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qlsb_q, qlsb_d;

  // State, iteration counter and captured Booth pair; reset wins over all.
  always_ff @(posedge reloj) begin
    if (!reinicio) begin
      estado_q <= IDLE;
      cnt_q    <= '0;
      qlsb_q   <= 2'b00;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      qlsb_q   <= qlsb_d;
    end
  end

  // Next-state, counter and qlsb capture logic.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    qlsb_d   = qlsb_q;
    case (estado_q)
      IDLE: begin
        if (banderaValida) estado_d = CARGA;
      end
      CARGA: begin
        cnt_d    = CW'(N_BITS);
        estado_d = EVALUA;
      end
      EVALUA: begin
        // SUMA must use this captured pair, not whatever qlsb does later.
        qlsb_d = qlsb;
        if (qlsb == 2'b01 || qlsb == 2'b10) estado_d = SUMA;
        else                                estado_d = DESPLAZA;
      end
      SUMA: begin
        estado_d = DESPLAZA;
      end
      DESPLAZA: begin
        // Saturating decrement; a zero count is treated as the last round.
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) estado_d = LISTO;
        else                 estado_d = EVALUA;
      end
      LISTO: begin
        estado_d = IDLE;
      end
      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    controladorMult = '0;
    banderaLista    = 1'b0;
    ocupado         = (estado_q != IDLE);
    case (estado_q)
      CARGA: begin
        controladorMult.load_A = 1'b1;
        controladorMult.load_B = 1'b1;
      end
      SUMA: begin
        controladorMult.load_add = 1'b1;
        controladorMult.add_sub  = (qlsb_q == 2'b01);
      end
      DESPLAZA: begin
        controladorMult.shift_HQ_LQ_Q_1 = 1'b1;
      end
      LISTO: begin
        banderaLista = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign estado = estado_q;

endmodule

// File: tb/tb_control_multiplicacion.sv
// Self-checking bench for control_multiplicacion (N_BITS=4).
module tb_control_multiplicacion;
  import paquete_multiplicacion::*;

  localparam int W = 10;

  logic          reloj = 1'b0;
  logic          reinicio;
  logic          banderaValida;
  logic [1:0]    qlsb;
  mult_control_t controladorMult;
  logic          banderaLista;
  logic          ocupado;
  estado_t       estado;

  logic [W-1:0] exp_q[$];
  logic [1:0]   drv_q[$];
  int           n_vec  = 0;
  int           n_miss = 0;

  control_multiplicacion #(.N_BITS(4)) dut (
    .reloj           (reloj),
    .reinicio        (reinicio),
    .banderaValida   (banderaValida),
    .qlsb            (qlsb),
    .controladorMult (controladorMult),
    .banderaLista    (banderaLista),
    .ocupado         (ocupado),
    .estado          (estado)
  );

  // Clock
  always #5 reloj = ~reloj;

  // Single checking task
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected output word {load_A,load_B,load_add,shift,add_sub,lista,ocupado,state}
  function automatic logic [W-1:0] exp_word(input estado_t st, input logic as);
    logic la, ladd, sh, a, li;
    la   = (st == CARGA);
    ladd = (st == SUMA);
    sh   = (st == DESPLAZA);
    a    = (st == SUMA) ? as : 1'b0;
    li   = (st == LISTO);
    return {la, la, ladd, sh, a, li, (st != IDLE), 3'(st)};
  endfunction

  function automatic logic [1:0] rnd2();
    return 2'($urandom_range(0, 3));
  endfunction

  // Push one expected cycle plus the qlsb value to drive during that cycle
  task automatic push(input estado_t st, input logic as, input logic [1:0] d);
    exp_q.push_back(exp_word(st, as));
    drv_q.push_back(d);
  endtask

  // Expected sequence of one operation; pat holds the Booth pair per round
  task automatic push_op(input logic [7:0] pat, input int suma_drv, output int nsuma);
    logic [1:0] q;
    nsuma = 0;
    push(CARGA, 1'b0, rnd2());
    for (int i = 0; i < 4; i++) begin
      q = pat[2*i +: 2];
      push(EVALUA, 1'b0, q);
      if (q == 2'b01 || q == 2'b10) begin
        nsuma++;
        push(SUMA, (q == 2'b01), (suma_drv < 0) ? rnd2() : 2'(suma_drv));
      end
      push(DESPLAZA, 1'b0, rnd2());
    end
    push(LISTO, 1'b0, rnd2());
  endtask

  // One clock: sample after the edge, compare, drive qlsb for this cycle
  task automatic tick(input string tag, output logic lista);
    logic [W-1:0] obs;
    @(posedge reloj);
    #1;
    obs = {controladorMult.load_A, controladorMult.load_B, controladorMult.load_add,
           controladorMult.shift_HQ_LQ_Q_1, controladorMult.add_sub,
           banderaLista, ocupado, 3'(estado)};
    lista = banderaLista;
    if (exp_q.size() > 0) begin
      check(tag, obs, exp_q.pop_front());
      qlsb = (drv_q.size() > 0) ? drv_q.pop_front() : rnd2();
    end else begin
      check({tag, "_underflow"}, obs, '1);
    end
  endtask

  // Full single operation with a one-cycle request pulse and latency check
  task automatic run_op(input string tag, input logic [7:0] pat, input int suma_drv);
    int nsuma, len, lat;
    logic l;
    push_op(pat, suma_drv, nsuma);
    push(IDLE, 1'b0, rnd2());
    len = exp_q.size();
    lat = -1;
    banderaValida = 1'b1;
    for (int k = 0; k < len; k++) begin
      tick(tag, l);
      if (k == 0) banderaValida = 1'b0;
      if (l && lat < 0) lat = k + 1;
    end
    check({tag, "_latency"}, W'(lat), W'(10 + nsuma));
  endtask

  initial begin
    logic l;
    int   nsuma;
    int   pulses[$];
    reinicio      = 1'b0;
    banderaValida = 1'b1;
    qlsb          = 2'b00;

    // Reset held with a pending request: stays IDLE, outputs quiet
    for (int i = 0; i < 3; i++) push(IDLE, 1'b0, rnd2());
    for (int i = 0; i < 3; i++) tick("reset_hold", l);
    reinicio      = 1'b1;
    banderaValida = 1'b0;
    push(IDLE, 1'b0, rnd2());
    tick("idle_after_reset", l);

    // Constant Booth pairs
    run_op("op_00", 8'b00_00_00_00, -1);
    run_op("op_01", 8'b01_01_01_01, -1);
    run_op("op_10", 8'b10_10_10_10, -1);
    run_op("op_11", 8'b11_11_11_11, -1);
    // qlsb moves 10 -> 00 during every SUMA: subtract must still be used
    run_op("op_10_glitch", 8'b10_10_10_10, 0);
    run_op("op_mixed", 8'b11_00_10_01, 3);
    for (int r = 0; r < 4; r++) run_op("op_rand", 8'($urandom_range(0, 255)), -1);

    // Reset during the second SUMA aborts with no completion pulse
    push(CARGA, 1'b0, 2'b01);
    push(EVALUA, 1'b0, 2'b01);
    push(SUMA, 1'b1, 2'b01);
    push(DESPLAZA, 1'b0, 2'b01);
    push(EVALUA, 1'b0, 2'b01);
    push(SUMA, 1'b1, 2'b01);
    banderaValida = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick("abort_seq", l);
      banderaValida = 1'b0;
    end
    reinicio = 1'b0;
    push(IDLE, 1'b0, rnd2());
    tick("abort_reset", l);
    reinicio = 1'b1;
    for (int i = 0; i < 4; i++) push(IDLE, 1'b0, rnd2());
    for (int i = 0; i < 4; i++) tick("abort_idle", l);

    // Request held for 30 cycles: back-to-back operations, no restart while busy
    for (int op = 0; op < 3; op++) begin
      push_op(8'b00_00_00_00, -1, nsuma);
      push(IDLE, 1'b0, rnd2());
    end
    banderaValida = 1'b1;
    qlsb          = 2'b00;
    for (int c = 1; c <= 33; c++) begin
      tick("b2b", l);
      if (l) pulses.push_back(c);
      banderaValida = (c < 30);
    end
    check("b2b_count", W'(pulses.size()), W'(3));
    check("b2b_first", (pulses.size() > 0) ? W'(pulses[0]) : '1, W'(10));
    check("b2b_second", (pulses.size() > 1) ? W'(pulses[1]) : '1, W'(21));
    check("b2b_left", W'(exp_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
